mips_mc_ctrl: RTL

Multicycle control unit that sequences a shared-memory MIPS datapath through fetch, decode, execute, memory and writeback states. It replaces the single-cycle decoder pair for the multicycle core. It drives per-state enables, mux selects and the ALU opcode, and stalls on a ready/valid memory handshake so the same memory serves both instruction and data accesses.

---
 rtl/mips_mc_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with ready/valid memory stalls and a sticky bus-error timeout.
// Define MIPS_MC_ILLEGAL_TRAP_EN to make unknown instructions a terminal trap (adds port 'illegal').
// State codes on 'state': 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTEXE,
// 7 RTWB, 8 IEXE, 9 IWB, 10 BRANCH, 11 JUMP, 12 ILLEGAL.
module mips_mc_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int WCNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       signext,
  output logic       shiftl16,
  output logic [3:0] alucontrol,
  output logic       bus_err,
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_IEXE    = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  state_t            st, st_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  logic              wait_st, timeout;
  logic              pcw, irw, mrd, mwr, rw;

  assign state   = st;
  assign wait_st = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  assign timeout = wait_st && !mem_ready && (WAIT_LIMIT != 0) &&
                   (wcnt == WCNT_W'(WAIT_LIMIT));

  // Enables and requests are forced low for as long as reset is held.
  assign pcwrite  = pcw & reset_n;
  assign irwrite  = irw & reset_n;
  assign memread  = mrd & reset_n;
  assign memwrite = mwr & reset_n;
  assign regwrite = rw  & reset_n;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign illegal = (st == S_ILLEGAL);
`endif

  // Any state change clears the counter, so entry to a wait state always starts from zero.
  always_comb begin
    wcnt_nx = '0;
    if (wait_st && !mem_ready && !timeout)
      wcnt_nx = (wcnt == '1) ? wcnt : wcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_FETCH;
      wcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      st   <= st_nx;
      wcnt <= wcnt_nx;
      if (timeout) bus_err <= 1'b1;
    end
  end

  always_comb begin
    st_nx      = st;
    pcw        = 1'b0;
    irw        = 1'b0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    rw         = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    alucontrol = ALU_AND;
    case (st)
      S_FETCH: begin
        mrd        = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        if (mem_ready) begin
          irw   = 1'b1;
          pcw   = 1'b1;
          st_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        signext    = 1'b1;
        alucontrol = ALU_ADD;
        case (op)
          6'b100011, 6'b101011:                       st_nx = S_MEMADR;
          6'b000000:                                  st_nx = S_RTEXE;
          6'b001000, 6'b001001, 6'b001101, 6'b001111: st_nx = S_IEXE;
          6'b000100, 6'b000101:                       st_nx = S_BRANCH;
          6'b000010:                                  st_nx = S_JUMP;
          default:                                    st_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        signext    = 1'b1;
        alucontrol = ALU_ADD;
        st_nx      = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mrd  = 1'b1;
        iord = 1'b1;
        if (mem_ready)    st_nx = S_MEMWB;
        else if (timeout) st_nx = S_FETCH;
      end
      S_MEMWB: begin
        rw       = 1'b1;
        memtoreg = 1'b1;
        st_nx    = S_FETCH;
      end
      S_MEMWR: begin
        mwr  = 1'b1;
        iord = 1'b1;
        if (mem_ready || timeout) st_nx = S_FETCH;
      end
      S_RTEXE: begin
        alusrca = 1'b1;
        st_nx   = S_RTWB;
        case (funct)
          6'b100000, 6'b100001: alucontrol = ALU_ADD;
          6'b100010, 6'b100011: alucontrol = ALU_SUB;
          6'b100100:            alucontrol = ALU_AND;
          6'b100101:            alucontrol = ALU_OR;
          6'b101010:            alucontrol = ALU_SLT;
          6'b101011:            alucontrol = ALU_SLTU;
          default:              st_nx      = S_ILLEGAL;
        endcase
      end
      S_RTWB: begin
        rw     = 1'b1;
        regdst = 1'b1;
        st_nx  = S_FETCH;
      end
      S_IEXE: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        st_nx   = S_IWB;
        case (op)
          6'b001101: alucontrol = ALU_OR;
          6'b001111: begin
            shiftl16   = 1'b1;
            alucontrol = ALU_ADD;
          end
          default: begin
            signext    = 1'b1;
            alucontrol = ALU_ADD;
          end
        endcase
      end
      S_IWB: begin
        rw    = 1'b1;
        st_nx = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcw        = zero ^ op[0];
        st_nx      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcw   = 1'b1;
        st_nx = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        st_nx = S_ILLEGAL;
`else
        st_nx = S_FETCH;
`endif
      end
      default: st_nx = S_FETCH;
    endcase
  end

endmodule
